// File: rtl/fp_pkg.sv
// Shared FP32 alignment constants, field positions and sequencer state type.
// Build option: define STICKY_EN to make man_small[0] a sticky bit.
package fp_pkg;

  localparam int EXP_W     = 8;
  localparam int MAN_W     = 24;
  localparam int ALIGN_W   = 27;
  localparam int MAX_SHIFT = 27;
  localparam int GUARD_W   = 3;
  localparam int CNT_W     = 5;

  localparam int SIGN_POS  = 31;
  localparam int EXP_MSB   = 30;
  localparam int EXP_LSB   = 23;
  localparam int FRAC_MSB  = 22;

  typedef enum logic [1:0] {
    IDLE,
    CMP,
    SHIFT,
    DONE
  } state_t;

  function automatic logic [MAN_W-1:0] mant_of(
    input logic [31:0] x
  );
    return {|x[EXP_MSB:EXP_LSB], x[FRAC_MSB:0]};
  endfunction

endpackage

// File: rtl/fp_align_sequencer_if.sv
// Operand-in / aligned-result-out handshake bundle for fp_align_sequencer.
// Build option: STICKY_EN only changes man_small contents, not this bundle.
interface fp_align_sequencer_if;
  import fp_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [31:0]        a;
  logic [31:0]        b;
  logic               out_valid;
  logic               out_ready;
  logic [EXP_W-1:0]   exp_out;
  logic [MAN_W-1:0]   man_big;
  logic [ALIGN_W-1:0] man_small;
  logic               sign_big;
  logic               sign_small;
  logic               swap;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, exp_out,
    input  man_big, man_small,
    input  sign_big, sign_small, swap
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, exp_out,
    output man_big, man_small,
    output sign_big, sign_small, swap
  );

endinterface

// File: rtl/fp_align_sequencer_expdiff.sv
// Exponent comparator: absolute difference and swap flag.
// Build option: unaffected by STICKY_EN.
module exponent_difference
  import fp_pkg::*;
(
  input  logic [EXP_W-1:0] ea,
  input  logic [EXP_W-1:0] eb,
  output logic [EXP_W-1:0] diff,
  output logic             swap
);

  assign swap = (ea < eb);
  assign diff = swap ? (eb - ea) : (ea - eb);

endmodule

// File: rtl/fp_align_sequencer.sv
// Multi-cycle FP32 operand aligner: compare exponents, shift smaller right.
// Build option: define STICKY_EN to OR shifted-out bits into man_small[0].
module fp_align_sequencer
  import fp_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  fp_align_sequencer_if.slave io
);

  state_t             state;
  state_t             state_n;
  logic [31:0]        a_q;
  logic [31:0]        b_q;
  logic [CNT_W-1:0]   k_q;
  logic [CNT_W-1:0]   k_ld;
  logic [ALIGN_W-1:0] sr_q;
  logic [ALIGN_W-1:0] sr_nx;
  logic [EXP_W-1:0]   exp_q;
  logic [MAN_W-1:0]   man_big_q;
  logic               sign_big_q;
  logic               sign_small_q;
  logic               swap_q;
  logic [EXP_W-1:0]   diff;
  logic               swap;
  logic [31:0]        big_op;
  logic [31:0]        small_op;

  exponent_difference u_expdiff (
    .ea   (a_q[EXP_MSB:EXP_LSB]),
    .eb   (b_q[EXP_MSB:EXP_LSB]),
    .diff (diff),
    .swap (swap)
  );

  assign big_op   = swap ? b_q : a_q;
  assign small_op = swap ? a_q : b_q;

  assign k_ld = (diff > EXP_W'(MAX_SHIFT))
              ? CNT_W'(MAX_SHIFT)
              : diff[CNT_W-1:0];

`ifdef STICKY_EN
  assign sr_nx = {1'b0, sr_q[ALIGN_W-1:2],
                  sr_q[1] | sr_q[0]};
`else
  assign sr_nx = {1'b0, sr_q[ALIGN_W-1:1]};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (io.in_valid) state_n = CMP;
      CMP:   state_n = (k_ld != '0) ? SHIFT : DONE;
      SHIFT: if (k_q == CNT_W'(1)) state_n = DONE;
      DONE:  if (io.out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q          <= '0;
      b_q          <= '0;
      k_q          <= '0;
      sr_q         <= '0;
      exp_q        <= '0;
      man_big_q    <= '0;
      sign_big_q   <= 1'b0;
      sign_small_q <= 1'b0;
      swap_q       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (io.in_valid) begin
            a_q <= io.a;
            b_q <= io.b;
          end
        end
        CMP: begin
          exp_q        <= big_op[EXP_MSB:EXP_LSB];
          man_big_q    <= mant_of(big_op);
          sr_q         <= {mant_of(small_op), GUARD_W'(0)};
          k_q          <= k_ld;
          sign_big_q   <= big_op[SIGN_POS];
          sign_small_q <= small_op[SIGN_POS];
          swap_q       <= swap;
        end
        SHIFT: begin
          sr_q <= sr_nx;
          k_q  <= k_q - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign io.in_ready   = (state == IDLE);
  assign io.out_valid  = (state == DONE);
  assign io.exp_out    = exp_q;
  assign io.man_big    = man_big_q;
  assign io.man_small  = sr_q;
  assign io.sign_big   = sign_big_q;
  assign io.sign_small = sign_small_q;
  assign io.swap       = swap_q;

endmodule

// File: tb/tb_fp_align_sequencer.sv
// Scoreboard bench for fp_align_sequencer with a reference alignment model.
// Build option: define STICKY_EN for both RTL and bench to test sticky mode.
module tb_fp_align_sequencer;
  import fp_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp_align_sequencer_if bus();

  fp_align_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  typedef struct {
    logic [7:0]  e;
    logic [23:0] mb;
    logic [26:0] ms;
    logic        sb;
    logic        ss;
    logic        sw;
    int          lat;
    int          acc;
    int          stall;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit seen = 0;
  bit idle_chk = 0;
  int stall_left = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string n, logic [31:0] act,
                     logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t",
               n, act, want, $time);
    end
  endtask

  function automatic exp_t model(logic [31:0] a,
                                 logic [31:0] b,
                                 int acc, int stall);
    exp_t r;
    int ea;
    int eb;
    int d;
    int k;
    logic [31:0] big;
    logic [31:0] sml;
    longint ms;
    longint lost;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    r.sw = (ea < eb);
    big = r.sw ? b : a;
    sml = r.sw ? a : b;
    d = r.sw ? eb - ea : ea - eb;
    k = (d > 27) ? 27 : d;
    ms = longint'({|sml[30:23], sml[22:0]}) * 8;
    r.ms = 27'(ms >> k);
    lost = ms & ((64'sd1 <<< k) - 1);
`ifdef STICKY_EN
    if (lost != 0) r.ms[0] = 1'b1;
`else
    if (lost != 0) r.ms = r.ms;
`endif
    r.e = big[30:23];
    r.mb = {|big[30:23], big[22:0]};
    r.sb = big[31];
    r.ss = sml[31];
    r.lat = 2 + k;
    r.acc = acc;
    r.stall = stall;
    return r;
  endfunction

  initial begin
    exp_t cur;
    bus.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus.out_ready = 1'b0;
        seen = 0;
        idle_chk = 0;
      end else begin
        if (idle_chk) begin
          chk("idle_in_ready", 32'(bus.in_ready), 1);
          chk("idle_out_valid", 32'(bus.out_valid), 0);
          idle_chk = 0;
        end
        if (bus.out_valid) begin
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_valid actual=1 required=0");
            bus.out_ready = 1'b1;
          end else begin
            cur = q[0];
            if (!seen) begin
              seen = 1;
              chk("latency", 32'(cyc + 1 - cur.acc), 32'(cur.lat));
              stall_left = cur.stall;
            end
            chk("exp_out", 32'(bus.exp_out), 32'(cur.e));
            chk("man_big", 32'(bus.man_big), 32'(cur.mb));
            chk("man_small", 32'(bus.man_small), 32'(cur.ms));
            chk("sign_big", 32'(bus.sign_big), 32'(cur.sb));
            chk("sign_small", 32'(bus.sign_small), 32'(cur.ss));
            chk("swap", 32'(bus.swap), 32'(cur.sw));
            chk("in_ready_done", 32'(bus.in_ready), 0);
            if (stall_left > 0) begin
              stall_left--;
              bus.out_ready = 1'b0;
            end else begin
              bus.out_ready = 1'b1;
              void'(q.pop_front());
              seen = 0;
              idle_chk = 1;
            end
          end
        end else begin
          bus.out_ready = 1'b0;
        end
      end
    end
  end

  task automatic send(logic [31:0] a, logic [31:0] b,
                      int stall);
    int n = 0;
    while (!bus.in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout actual=0 required=1");
      return;
    end
    bus.a = a;
    bus.b = b;
    bus.in_valid = 1'b1;
    @(negedge clk);
    q.push_back(model(a, b, cyc, stall));
    bus.in_valid = 1'($urandom_range(0, 1));
    bus.a = $urandom;
    bus.b = $urandom;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout actual=%0d required=0",
               q.size());
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=done");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_man_small", 32'(bus.man_small), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    send(32'h3F800000, 32'h40000000, 0);
    send(32'h3FC00000, 32'h3FC00000, 0);
    send(32'h4B800000, 32'h3F800001, 0);
    send(32'h7F000000, 32'h3F800000, 0);
    send(32'hBF800000, 32'h40000000, 5);
    send(32'h00400000, 32'h00000001, 2);
    drain();

    send(32'h7F000000, 32'h3F800000, 0);
    repeat (10) @(negedge clk);
    chk("pre_rst_in_ready", 32'(bus.in_ready), 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 0);
    chk("midrst_in_ready", 32'(bus.in_ready), 1);
    chk("midrst_exp_out", 32'(bus.exp_out), 0);
    chk("midrst_man_big", 32'(bus.man_big), 0);
    chk("midrst_man_small", 32'(bus.man_small), 0);
    chk("midrst_signs", 32'({bus.sign_big, bus.sign_small}), 0);
    chk("midrst_swap", 32'(bus.swap), 0);
    q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send(32'h40400000, 32'hC0000000, 0);
    chk("post_rst_accepted", 32'(bus.in_ready), 0);
    drain();

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 3 == 0)
        rb[30:23] = ra[30:23] + 8'($urandom_range(0, 8)) - 8'd4;
      if (i % 7 == 0) ra[30:23] = 8'h00;
      send(ra, rb, int'($urandom_range(0, 3)));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
